fifo_rd_stream: RTL



---
 rtl/fifo_pkg.sv | 9 +
 rtl/stream_buf_2.sv | 68 ++++++
 rtl/fifo_rd_stream.sv | 73 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int FIFO_RD_LATENCY  = 1;
  localparam int STREAM_BUF_DEPTH = 2;

  typedef logic [1:0] buf_level_t;

endpackage

// File: rtl/stream_buf_2.sv
// Two-entry register buffer with 1-bit wrapping head/tail pointers, a word
// count and a synchronous clear that empties it without touching storage.
module stream_buf_2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output buf_level_t            count_o
);

  logic [DATA_WIDTH-1:0] entry_q [STREAM_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] entry_d [STREAM_BUF_DEPTH];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  buf_level_t            count_q, count_d;

  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push_i) begin
        entry_d[tail_q] = push_data_i;
        tail_d          = ~tail_q;
      end
      if (pop_i) begin
        head_d = ~head_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STREAM_BUF_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data_o = entry_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Adapts the 1-cycle-latency FIFO read port to a valid/ready stream through a
// two-entry holding buffer; supports synchronous flush of buffered and in-flight words.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_empty,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_level
);

  if (BUF_DEPTH != STREAM_BUF_DEPTH) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH must be 2");
  end

  logic       pend_q, pend_d;
  logic       discard_q, discard_d;
  logic       deq_s;
  logic       rd_acc_s;
  logic       push_s;
  logic       room_s;
  buf_level_t count_s;

  assign o_valid = (count_s != 2'd0);
  assign o_level = count_s;
  assign deq_s   = o_valid && i_ready;

  // Room counts the word already in flight; a same-cycle dequeue frees a slot.
  assign room_s   = ({1'b0, count_s} + {2'b00, pend_q}) < (3'd2 + {2'b00, deq_s});
  assign o_rd_en  = !i_rst && !i_flush && !i_rd_empty && room_s;
  assign rd_acc_s = o_rd_en && !i_rd_empty;

  // The FIFO has committed a pending word even if empty rises, so it is captured.
  assign push_s = pend_q && !discard_q && !i_flush;

  always_comb begin
    pend_d    = rd_acc_s;
    discard_d = i_flush && rd_acc_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      discard_q <= discard_d;
    end
  end

  stream_buf_2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .clr_i       (i_flush),
    .push_i      (push_s),
    .push_data_i (i_rd_data),
    .pop_i       (deq_s),
    .head_data_o (o_data),
    .count_o     (count_s)
  );

endmodule
